hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and HLT drain/halt sequencing.
// Outputs are combinational from state and inputs; state, drain counter and statistics are registered.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ifid_instr,
    input  logic        ifid_valid,
    input  logic        idex_regwrite,
    input  logic        idex_memtoreg,
    input  logic [3:0]  idex_reg_write_select,
    input  logic        ex_branch_taken,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        idex_wen,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    state_t     state;
    state_t     state_next;
    logic [1:0] drain_cnt;
    logic [1:0] drain_next;
    logic       stall_inc;
    logic       flush_inc;

    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       reads_rs;
    logic       reads_rt;
    logic       reads_rd;
    logic       src_match;
    logic       load_use;
    logic       halt_req;

    assign opcode = ifid_instr[15:12];
    assign rd     = ifid_instr[11:8];
    assign rs     = ifid_instr[7:4];
    assign rt     = ifid_instr[3:0];

    // Decode which register fields the instruction in ID actually reads
    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        reads_rd = 1'b0;
        if (!opcode[3]) begin
            reads_rs = 1'b1;
            reads_rt = 1'b1;
        end else if (opcode == 4'b1000) begin
            reads_rs = 1'b1;
        end else if (opcode == 4'b1001) begin
            reads_rs = 1'b1;
            reads_rd = 1'b1;
        end
    end

    assign src_match = (reads_rs && (rs == idex_reg_write_select)) ||
                       (reads_rt && (rt == idex_reg_write_select)) ||
                       (reads_rd && (rd == idex_reg_write_select));

    // r0 is hardwired to zero, so a load targeting it can never be a real dependency
    assign load_use = ifid_valid && idex_regwrite && idex_memtoreg &&
                      (idex_reg_write_select != 4'd0) && src_match;

    assign halt_req = ifid_valid && (opcode == 4'hF);

    // Next-state and output decode; branch beats load-use, which beats HLT
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        idex_wen   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;

        if (rst) begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        pc_wen     = 1'b0;
                        ifid_wen   = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (halt_req) begin
                        pc_wen     = 1'b0;
                        ifid_wen   = 1'b0;
                        state_next = DRAIN;
                        drain_next = DRAIN_CYCLES;
                    end
                end
                DRAIN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                        state_next = RUN;
                        drain_next = 2'd0;
                    end else begin
                        pc_wen     = 1'b0;
                        ifid_wen   = 1'b0;
                        idex_flush = 1'b1;
                        drain_next = drain_cnt - 2'd1;
                        if (drain_cnt == 2'd1) begin
                            state_next = HALTED;
                        end
                    end
                end
                HALTED: begin
                    pc_wen   = 1'b0;
                    ifid_wen = 1'b0;
                    idex_wen = 1'b0;
                    halted   = 1'b1;
                end
                default: begin
                    state_next = RUN;
                    drain_next = 2'd0;
                end
            endcase
        end
    end

    // State register and drain countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Saturating statistics counters for load-use bubbles and branch flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_inc && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_inc && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule
